// File: rtl/read_resp_chan_mngr_if.sv
// Read request (AR), read data (R) and backing-memory line-read signals of one responder.
// The slave modport is the responder; master is the fabric/memory side driving it.
interface read_resp_chan_mngr_if;
  logic         arvalid;
  logic         arready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic         rvalid;
  logic         rready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic         rlast;
  logic         mem_rreq;
  logic [31:0]  mem_raddr;
  logic         mem_rack;
  logic [127:0] mem_rdata;

  modport slave (
    input  arvalid, arid, araddr, rready, mem_rack, mem_rdata,
    output arready, rvalid, rid, rdata, rlast, mem_rreq, mem_raddr
  );

  modport master (
    output arvalid, arid, araddr, rready, mem_rack, mem_rdata,
    input  arready, rvalid, rid, rdata, rlast, mem_rreq, mem_raddr
  );
endinterface

// File: rtl/read_resp_chan_mngr.sv
// Queues AR requests, reads one 128-bit line per request, returns it as a 4x32-bit R burst; first beat 3 cycles after AR.
// arready drops only when the request FIFO is full; rready low holds the current beat unchanged.
module read_resp_chan_mngr #(
  parameter int RQ_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  read_resp_chan_mngr_if.slave bus
);

  localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int CW = $clog2(RQ_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RQ_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MREQ = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  typedef struct packed {
    logic [3:0]  id;
    logic [27:0] line_addr;
  } req_t;

  req_t          rq_mem [RQ_DEPTH];
  req_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    state;
  logic [1:0]    beat;
  logic [3:0]    cur_id;
  logic [27:0]   cur_addr;
  logic [127:0]  line;

  logic          push;
  logic          pop;
  logic          last_hs;
  logic          unused_addr_lsb;

  // Requests are line aligned, so the byte offset is dropped on entry.
  assign unused_addr_lsb = ^bus.araddr[3:0];

  assign bus.arready = (count != FULL_CNT);
  assign push        = bus.arvalid && bus.arready;
  assign last_hs     = (state == SEND) && bus.rready && (beat == 2'd3);
  assign pop         = (count != '0) && ((state == IDLE) || last_hs);
  assign head        = rq_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      rq_mem[wr_ptr] <= '{id: bus.arid, line_addr: bus.araddr[31:4]};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= 2'd0;
      cur_id   <= 4'd0;
      cur_addr <= 28'd0;
      line     <= 128'd0;
    end else begin
      if (pop) begin
        cur_id   <= head.id;
        cur_addr <= head.line_addr;
      end
      case (state)
        IDLE: begin
          if (pop) state <= MREQ;
        end
        MREQ: begin
          if (bus.mem_rack) begin
            line  <= bus.mem_rdata;
            beat  <= 2'd0;
            state <= SEND;
          end
        end
        SEND: begin
          if (bus.rready) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) state <= pop ? MREQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rvalid    = (state == SEND);
  assign bus.rid       = cur_id;
  assign bus.rdata     = line[{beat, 5'd0} +: 32];
  assign bus.rlast     = (state == SEND) && (beat == 2'd3);
  assign bus.mem_rreq  = (state == MREQ);
  assign bus.mem_raddr = {cur_addr, 4'b0000};

endmodule

// File: doc/read_resp_chan_mngr.md
# read_resp_chan_mngr

Responder (slave) side of the read request/data channel pair used by the bus masters. It accepts read requests on the AR channel into a small request FIFO and fetches one 128-bit line per request from a backing memory port. It then returns that line as a fixed 4-beat, 32-bit R burst carrying the request ID, with `rlast` on the fourth beat. It sits between the bus fabric and a memory or peripheral that serves line reads.

## Interface
- `RQ_DEPTH`, 2: request FIFO depth; power of two, ≥2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arvalid`  in  1  read request valid.
- `arready`  out  1  request accepted when high together with `arvalid`.
- `arid`  in  4  request ID.
- `araddr`  in  32  byte address; bits [3:0] ignored (line aligned).
- `rvalid`  out  1  read data beat valid.
- `rready`  in  1  master accepts the beat.
- `rid`  out  4  ID of the request being returned.
- `rdata`  out  32  beat data.
- `rlast`  out  1  high on beat 3 (final beat).
- `mem_rreq`  out  1  line read request to backing memory.
- `mem_raddr`  out  32  line address, `{araddr[31:4],4'b0}`.
- `mem_rack`  in  1  memory returns `mem_rdata` this cycle.
- `mem_rdata`  in  128  line data; valid only while `mem_rack`=1.

## Operation
- Request FIFO: entries hold `{arid, araddr[31:4]}`; count register 0..RQ_DEPTH; push on `arvalid && arready`; `arready = (count != RQ_DEPTH)`, combinational from registered count only.
- FSM states: IDLE, MREQ, SEND.
- IDLE: if FIFO non-empty, pop the head into `cur_id`/`cur_addr` and go to MREQ.
- MREQ: `mem_rreq`=1 with `mem_raddr` stable. On `mem_rack`, capture `mem_rdata` into the line register, clear the beat counter and go to SEND. `mem_rack` outside MREQ is ignored.
- SEND: `rvalid`=1, `rid`=`cur_id`, `rdata`=`line[beat*32 +: 32]` (beat 0 = bits [31:0]), `rlast`=(beat==3).
  - Each `rvalid && rready` increments the 2-bit beat counter.
  - On the beat-3 handshake: if the FIFO is non-empty, pop and go to MREQ; otherwise go to IDLE.
- Push and pop in the same cycle leave count unchanged. The FIFO pointers wrap modulo RQ_DEPTH.
- Beats are returned strictly in request order; IDs are not reordered.

## Timing
- Reset values: `rvalid`, `rlast`, `mem_rreq` = 0; `rid`, `rdata`, `mem_raddr` = 0; `arready` = 1 (count = 0); state = IDLE; beat = 0; FIFO empty.
- Reset asserted mid-burst aborts the burst immediately and drops all queued requests. No beat is issued after reset releases until a new AR is accepted.
- Minimum latency: AR handshake in cycle T into an empty FIFO with FSM in IDLE.
  - Pop occurs in T+1.
  - `mem_rreq` is high in T+2.
  - With `mem_rack` in T+2, first `rvalid` is in T+3.
  - Each extra memory wait cycle adds one cycle.
- Beats flow at one per cycle while `rready`=1. Last beat at T+6 minimum.
- Between bursts there is a 1-cycle MREQ slot at minimum. No R beat is issued in MREQ.
- R hold rule: while `rvalid`=1 and `rready`=0, `rid`/`rdata`/`rlast` stay stable and `rvalid` stays high.
- `mem_rreq` stays high until `mem_rack`, with `mem_raddr` held stable throughout.
- When full, `arready` is 0. A pop in cycle C makes `arready`=1 in C+1; there is no same-cycle fall-through.

## Test plan
- Single read: AR id=4'h3, addr=32'h0000_1238, memory returns 128'h4444_4444_3333_3333_2222_2222_1111_1111 with `mem_rack` in the first MREQ cycle -> `mem_raddr`=32'h0000_1230. Beats 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444 in T+3..T+6, `rid`=3 on all, `rlast` only on beat 4.
- Backpressure: same read with `rready` low for 2 cycles on beat 1 -> beat 1 data/rid/rlast unchanged during the stall; still exactly 4 beats, no duplicates.
- FIFO full: 3 ARs (ids 1, 2, 3) issued back-to-back with memory stalled (`mem_rack`=0) -> ids 1 and 2 accepted; `arready` low once two entries are queued. Id 3 is accepted only after a pop. Bursts return in order 1, 2, 3.
- Memory latency: `mem_rack` delayed 5 cycles -> `mem_rreq` high for 6 cycles with stable address; `rvalid` low throughout MREQ.
- Back-to-back: 2 queued requests, `rready`=1 -> second burst's `mem_rreq` is high the cycle after the first burst's `rlast` handshake.
- Reset mid-burst: `rst_n` low during beat 2 -> `rvalid`=0 and `arready`=1 immediately. After release, no beats until a new AR is accepted.
